// File: rtl/bfp_pkg.sv
// Shared widths and payload pieces for the block-floating-point output stage.
// Widths are derived from the BFP mantissa size and the target float format.
package bfp_pkg;

    function automatic int calc_pw(input int v, input int bfpm);
        return 2 * (bfpm + 2) + $clog2(v);
    endfunction

    function automatic int calc_ew(input int bit_w, input int fpm);
        return bit_w - fpm - 1;
    endfunction

    function automatic int calc_bias(input int ew);
        return (2 ** (ew - 1)) - 1;
    endfunction

    // Raw exponent width: room for in_exp + p - 2*BFPM plus a rounding carry, signed.
    function automatic int calc_xw(input int ew, input int pw);
        return ew + $clog2(pw) + 2;
    endfunction

    localparam int BIAS = calc_bias(calc_ew(32, 23));

    typedef struct packed {
        logic sign;
        logic zero;
    } bfp_ctrl_t;

endpackage

// File: rtl/bfp_normalize_lzd.sv
// Combinational leading-one detector: index of the highest set bit and an all-zero flag.
module lzd #(
    parameter int W = 16,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  a_i,
    output logic [IW-1:0] idx_o,
    output logic          zero_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < W; i++) begin
            if (a_i[i]) idx_o = IW'(i);
        end
    end

    assign zero_o = ~|a_i;

endmodule

// File: rtl/bfp_normalize.sv
// Converts a signed fixed-point dot-product sum plus block exponent into an IEEE-754 word.
// Three-stage pipeline (magnitude, normalize, round/pack) with one global stall enable.
module bfp_normalize
    import bfp_pkg::*;
#(
    parameter int V    = 8,
    parameter int BIT  = 32,
    parameter int FPM  = 23,
    parameter int BFPM = 4,
    localparam int PW  = calc_pw(V, BFPM),
    localparam int EW  = calc_ew(BIT, FPM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    input  logic [EW-1:0] in_exp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BIT-1:0] out_data,
    output logic          out_ovf,
    output logic          out_unf
);

    localparam int XW = calc_xw(EW, PW);
    localparam int LW = $clog2(PW + 1);
    localparam logic signed [XW-1:0] E_MAX  = XW'((2 ** EW) - 1);
    localparam logic signed [XW-1:0] E_ZERO = '0;

    typedef struct packed {
        bfp_ctrl_t               ctrl;
        logic [PW:0]             mag;
        logic signed [XW-1:0]    exp;
    } stage_t;

    stage_t s1_d, s1_q, s2_d, s2_q;
    logic   s1_v_q, s2_v_q;
    logic   out_valid_q, out_ovf_q, out_unf_q, out_ovf_d, out_unf_d;
    logic [BIT-1:0] out_data_q, out_data_d;
    logic   en;

    // Reset forces readiness so upstream never sees a stall while the pipe is being flushed.
    assign en       = reset || !(out_valid_q && !out_ready);
    assign in_ready = en;

    logic [PW:0] prod_ext;
    assign prod_ext = {in_prod[PW-1], in_prod};

    always_comb begin
        s1_d.ctrl.sign = in_prod[PW-1];
        s1_d.mag       = in_prod[PW-1] ? -prod_ext : prod_ext;
        s1_d.ctrl.zero = (s1_d.mag == '0);
        s1_d.exp       = XW'(in_exp);
    end

    logic [LW-1:0] lead_idx;
    logic          lead_zero;

    lzd #(.W(PW + 1)) u_lzd (
        .a_i    (s1_q.mag),
        .idx_o  (lead_idx),
        .zero_o (lead_zero)
    );

    always_comb begin
        s2_d.ctrl.sign = s1_q.ctrl.sign;
        s2_d.ctrl.zero = s1_q.ctrl.zero | lead_zero;
        s2_d.mag       = s1_q.mag << (LW'(PW) - lead_idx);
        s2_d.exp       = s1_q.exp + XW'(lead_idx) - XW'(2 * BFPM);
    end

    logic [FPM-1:0] frac_c;
    logic           carry_c;

    generate
        if (PW > FPM) begin : g_round
            localparam int GB = PW - 1 - FPM;
            logic [FPM-1:0] trunc;
            logic [FPM:0]   sum;
            logic           guard, sticky, rnd;

            assign trunc = s2_q.mag[PW-1 -: FPM];
            assign guard = s2_q.mag[GB];
            if (GB > 0) begin : g_sticky
                assign sticky = |s2_q.mag[GB-1:0];
            end else begin : g_nosticky
                assign sticky = 1'b0;
            end
            assign rnd     = guard & (sticky | trunc[0]);
            assign sum     = {1'b0, trunc} + {{FPM{1'b0}}, rnd};
            assign carry_c = sum[FPM];
            assign frac_c  = sum[FPM] ? '0 : sum[FPM-1:0];
        end else if (PW == FPM) begin : g_exact
            assign frac_c  = s2_q.mag[PW-1:0];
            assign carry_c = 1'b0;
        end else begin : g_pad
            assign frac_c  = {s2_q.mag[PW-1:0], {(FPM - PW){1'b0}}};
            assign carry_c = 1'b0;
        end
    endgenerate

    logic signed [XW-1:0] e_rnd;
    logic                 s3_zero;

    always_comb begin
        out_data_d = '0;
        out_ovf_d  = 1'b0;
        out_unf_d  = 1'b0;
        e_rnd      = s2_q.exp + XW'(carry_c);
        s3_zero    = s2_q.ctrl.zero | ~s2_q.mag[PW];
        if (s3_zero) begin
            out_data_d = '0;
        end else if (e_rnd >= E_MAX) begin
            out_data_d = {s2_q.ctrl.sign, {EW{1'b1}}, {FPM{1'b0}}};
            out_ovf_d  = 1'b1;
        end else if (e_rnd <= E_ZERO) begin
            out_data_d = {s2_q.ctrl.sign, {(BIT - 1){1'b0}}};
            out_unf_d  = 1'b1;
        end else begin
            out_data_d = {s2_q.ctrl.sign, e_rnd[EW-1:0], frac_c};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q      <= 1'b0;
            s1_q        <= '0;
            s2_v_q      <= 1'b0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else if (en) begin
            s1_v_q      <= in_valid;
            s1_q        <= s1_d;
            s2_v_q      <= s1_v_q;
            s2_q        <= s2_d;
            out_valid_q <= s2_v_q;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_unf_q   <= out_unf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;

endmodule

// File: tb/tb_bfp_normalize.sv
// Directed bench for bfp_normalize: default config (PW=15) and BFPM=12 (PW=31) for rounding.
module tb_bfp_normalize;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf, a_out_unf;
    logic [14:0] a_in_prod;
    logic [7:0]  a_in_exp;
    logic [31:0] a_out_data;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_out_unf;
    logic [30:0] b_in_prod;
    logic [7:0]  b_in_exp;
    logic [31:0] b_out_data;

    bfp_normalize u_dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_in_prod), .in_exp(a_in_exp),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_ovf(a_out_ovf), .out_unf(a_out_unf)
    );

    bfp_normalize #(.BFPM(12)) u_dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod), .in_exp(b_in_exp),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_ovf(b_out_ovf), .out_unf(b_out_unf)
    );

    typedef struct {
        logic [31:0] prod;
        logic [7:0]  ex;
        logic [31:0] data;
        logic        ovf;
        logic        unf;
        bit          big;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input bit big, input logic [31:0] p,
                                input logic [7:0] e, input logic [31:0] d,
                                input logic o, input logic u);
        vec_t v;
        v.name = n; v.big = big; v.prod = p; v.ex = e; v.data = d; v.ovf = o; v.unf = u;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int   n;
        logic ov;
        @(negedge clk);
        if (v.big) begin
            b_in_valid = 1'b1; b_in_prod = v.prod[30:0]; b_in_exp = v.ex;
        end else begin
            a_in_valid = 1'b1; a_in_prod = v.prod[14:0]; a_in_exp = v.ex;
        end
        #1;
        chk({v.name, " in_ready"}, 32'(v.big ? b_in_ready : a_in_ready), 32'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        n  = 1;
        ov = v.big ? b_out_valid : a_out_valid;
        while (!ov && n < 10) begin
            @(posedge clk); #1;
            n++;
            ov = v.big ? b_out_valid : a_out_valid;
        end
        chk({v.name, " latency"}, 32'(n), 32'd3);
        chk({v.name, " data"}, v.big ? b_out_data : a_out_data, v.data);
        chk({v.name, " ovf"}, 32'(v.big ? b_out_ovf : a_out_ovf), 32'(v.ovf));
        chk({v.name, " unf"}, 32'(v.big ? b_out_unf : a_out_unf), 32'(v.unf));
    endtask

    logic [14:0] s_prod [8];
    logic [31:0] s_exp  [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sent, got, stalls;
        logic held;
        logic [31:0] held_data;
        logic acc;

        reset = 1'b1;
        a_in_valid = 1'b0; a_in_prod = '0; a_in_exp = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_prod = '0; b_in_exp = '0; b_out_ready = 1'b1;

        vecs.push_back(mk("one",        0, 32'd256,   8'd127, 32'h3F800000, 0, 0));
        vecs.push_back(mk("82p0",       0, 32'd1312,  8'd131, 32'h42A40000, 0, 0));
        vecs.push_back(mk("minus_one",  0, 32'h7F00,  8'd127, 32'hBF800000, 0, 0));
        vecs.push_back(mk("zero",       0, 32'd0,     8'd77,  32'h00000000, 0, 0));
        vecs.push_back(mk("ovf",        0, 32'd256,   8'd255, 32'h7F800000, 1, 0));
        vecs.push_back(mk("unf",        0, 32'd256,   8'd0,   32'h00000000, 0, 1));
        vecs.push_back(mk("most_neg",   0, 32'h4000,  8'd127, 32'hC2800000, 0, 0));
        vecs.push_back(mk("neg_unf",    0, 32'h7F00,  8'd0,   32'h80000000, 0, 1));
        vecs.push_back(mk("e_zero",     0, 32'd1,     8'd8,   32'h00000000, 0, 1));
        vecs.push_back(mk("e_one",      0, 32'd1,     8'd9,   32'h00800000, 0, 0));
        vecs.push_back(mk("e_254",      0, 32'd256,   8'd254, 32'h7F000000, 0, 0));
        vecs.push_back(mk("max_ovf",    0, 32'h3FFF,  8'd255, 32'h7F800000, 1, 0));
        vecs.push_back(mk("tie_even",   1, 32'h01000001, 8'd127, 32'h3F800000, 0, 0));
        vecs.push_back(mk("tie_odd",    1, 32'h01000003, 8'd127, 32'h3F800002, 0, 0));
        vecs.push_back(mk("rnd_carry",  1, 32'h01FFFFFF, 8'd127, 32'h40000000, 0, 0));
        vecs.push_back(mk("sticky_up",  1, 32'h10000011, 8'd127, 32'h41800001, 0, 0));
        vecs.push_back(mk("neg_tie",    1, 32'h7EFFFFFD, 8'd127, 32'hBF800002, 0, 0));
        vecs.push_back(mk("carry_ovf",  1, 32'h01FFFFFF, 8'd254, 32'h7F800000, 1, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("reset a out_valid", 32'(a_out_valid), 32'd0);
        chk("reset a out_data",  a_out_data, 32'd0);
        chk("reset a in_ready",  32'(a_in_ready), 32'd1);
        chk("reset b out_valid", 32'(b_out_valid), 32'd0);
        chk("reset b flags",     32'({b_out_ovf, b_out_unf}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back stream with a four-cycle consumer stall.
        for (int k = 0; k < 8; k++) s_prod[k] = 15'(256 * (k + 1));
        s_exp[0] = 32'h3F800000; s_exp[1] = 32'h40000000; s_exp[2] = 32'h40400000;
        s_exp[3] = 32'h40800000; s_exp[4] = 32'h40A00000; s_exp[5] = 32'h40C00000;
        s_exp[6] = 32'h40E00000; s_exp[7] = 32'h41000000;
        sent = 0; got = 0; stalls = 0; held = 1'b0; held_data = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            a_in_valid  = (sent < 8);
            a_in_prod   = (sent < 8) ? s_prod[sent] : 15'd0;
            a_in_exp    = 8'd127;
            a_out_ready = !(c >= 4 && c <= 7);
            #1;
            if (a_out_valid && !a_out_ready) begin
                stalls++;
                chk("stall in_ready", 32'(a_in_ready), 32'd0);
                if (held) chk("stall data stable", a_out_data, held_data);
                held = 1'b1;
                held_data = a_out_data;
            end else begin
                held = 1'b0;
                chk("stream in_ready", 32'(a_in_ready), 32'd1);
            end
            if (a_out_valid && a_out_ready) begin
                chk($sformatf("stream result %0d", got), a_out_data, s_exp[got]);
                got++;
            end
            acc = a_in_valid && a_in_ready;
            @(posedge clk);
            if (acc) sent++;
        end
        chk("stream sent", 32'(sent), 32'd8);
        chk("stream got",  32'(got),  32'd8);
        chk("stream stall cycles", 32'(stalls), 32'd4);
        @(negedge clk);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Reset with two results in flight while the output is stalled.
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_prod = 15'd256; a_in_exp = 8'd127;
        @(negedge clk);
        a_in_prod = 15'd512;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("pre-reset out_valid", 32'(a_out_valid), 32'd1);
        chk("in_ready during reset", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
        chk("post-reset out_valid", 32'(a_out_valid), 32'd0);
        chk("post-reset out_data",  a_out_data, 32'd0);
        chk("post-reset flags",     32'({a_out_ovf, a_out_unf}), 32'd0);
        chk("post-reset in_ready",  32'(a_in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        a_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("flushed out_valid %0d", k), 32'(a_out_valid), 32'd0);
        end
        run_vec(mk("after_reset", 0, 32'd1312, 8'd131, 32'h42A40000, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bfp_normalize.md
# bfp_normalize

Output stage of the block-floating-point dot-product pipeline; sits directly downstream of `vectProd`. It takes each signed fixed-point dot-product sum and its block exponent and converts them back to an IEEE-754 word of width BIT. The conversion is a 3-stage pipeline with valid/ready handshaking, round-to-nearest-even, and saturation/flush handling.

## Interface
- V, default 8: vector length; sets the growth bits in PW = 2*(BFPM+2)+$clog2(V).
- BIT, default 32: float word width.
- FPM, default 23: float fraction bits. EW = BIT-FPM-1 = exponent width. BIAS = 2**(EW-1)-1.
- BFPM, default 4: BFP mantissa fraction bits. The product carries 2*BFPM fraction bits.
- clk, input, 1: clock.
- reset, input, 1: reset, synchronous, active-high.
- in_valid, input, 1: in_prod and in_exp are valid.
- in_ready, output, 1: the stage accepts input this cycle.
- in_prod, input, PW: two's-complement dot-product sum, connected to `vectProd.outVectProd`.
- in_exp, input, EW: combined, re-biased block exponent, connected to `vectProd.outExp`.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: the consumer accepts out_data.
- out_data, output, BIT: float result.
- out_ovf, output, 1: result saturated to infinity. Qualified by out_valid.
- out_unf, output, 1: result flushed to zero. Qualified by out_valid.

## Operation
- Value represented at the input: in_prod × 2^(in_exp − BIAS − 2·BFPM).
- S1:
  - sign = in_prod MSB; mag = |in_prod|.
  - Most negative input: mag is taken in PW+1 bits, so no overflow.
  - zero flag = (mag == 0).
- S2:
  - Leading-one index p (0..PW) of mag.
  - Left-shift mag so the leading one lands at bit PW.
  - Raw biased exponent e = in_exp + p − 2·BFPM, signed, width EW+$clog2(PW)+2.
- S3, fraction:
  - Take the FPM bits below the leading one.
  - If PW > FPM, round to nearest even using guard plus sticky.
  - A rounding carry out of the fraction increments e and zeroes the fraction.
  - If PW ≤ FPM, zero-pad; no rounding.
- S3, packing, in priority order:
  - zero → all bits 0, flags 0.
  - e ≥ 2^EW−1 → {sign, all-ones exponent, 0 fraction}, out_ovf=1.
  - e ≤ 0 → {sign, 0…0}, out_unf=1. No denormals are produced.
  - otherwise → {sign, e[EW-1:0], fraction}.
- in_exp is never treated as NaN/Inf. All in_exp codes are plain numbers.

## Timing
- Three register stages, each with its own valid bit.
- Latency: accept on cycle N (in_valid && in_ready at the clk edge) → out_valid at cycle N+3 when no stalls occur.
- Throughput: one result per cycle.
- Handshake:
  - Global pipeline enable en = !(out_valid && !out_ready).
  - in_ready = en.
  - All stages advance only when en is high. Bubbles are not compressed.
- Stall: while out_valid=1 and out_ready=0, out_data, out_ovf and out_unf hold stable. No input is lost or duplicated.
- in_valid=0 with en=1 inserts a bubble; the S1 valid clears.
- Reset, at any time including mid-stream:
  - Next edge clears all stage valids; in-flight data is discarded.
  - out_valid=0, out_data=0, out_ovf=0, out_unf=0.
  - in_ready=1 during and after reset.
- Simultaneous out_ready rising and new input in the same cycle: the output is consumed and the new input is accepted in that cycle.

## Structure
- Shared package `bfp_pkg`:
  - width functions for PW and EW;
  - the BIAS constant;
  - a packed struct for the S1→S2→S3 payload (sign, zero, mag/shifted mag, exponent).
- Sub-module `lzd` (parameter W): combinational leading-one detector returning index and a zero flag. Used in S2.

## Test plan
Default parameters unless stated; PW=15.
- in_prod=256, in_exp=127 → out_data=0x3F800000, flags 0, out_valid exactly 3 cycles after accept.
- in_prod=1312, in_exp=131 (82.0) → 0x42A40000. in_prod=−256, in_exp=127 → 0xBF800000. in_prod=0, any in_exp → 0x00000000.
- in_prod=256, in_exp=255 → 0x7F800000 with out_ovf=1. in_prod=256, in_exp=0 → 0x00000000 with out_unf=1.
- BFPM=12 (PW=31), in_exp=127:
  - in_prod=2^24+1 → 0x3F800000 (tie to even);
  - in_prod=2^24+3 → 0x3F800002;
  - in_prod=2^25−1 → 0x40000000 (rounding carry bumps exponent).
- Stream of 8 back-to-back inputs with out_ready low for cycles 4–7: in_ready=0 during the stall, out_data stable, all 8 results emerge in order with none dropped.
- Assert reset with 2 results in flight: out_valid=0 the next cycle. Results for inputs issued after reset is released appear with normal 3-cycle latency.
